// File: rtl/branch_resolver.sv
// Branch resolver: in-order queue of fetch predictions, checked against execute outcomes.
// Mispredicts raise a registered one-cycle redirect and flush every younger entry.
module branch_resolver #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    input  logic [XLEN-1:0]  pred_fallthrough,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [XLEN-1:0]  res_target,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             empty,
    output logic             underflow_err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             taken_q  [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [XLEN-1:0]  ft_q     [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             redirect_q, redirect_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             underflow_q, underflow_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic             resolve;
    logic             mispredict;
    logic             push;
    logic [XLEN-1:0]  correct_pc;

    assign empty      = (count_q == '0);
    assign pred_ready = (count_q != (PTR_W+1)'(DEPTH));
    assign resolve    = res_valid && !empty;
    assign mispredict = resolve &&
                        ((res_taken != taken_q[rd_ptr_q]) ||
                         (res_taken && (res_target != target_q[rd_ptr_q])));
    assign correct_pc = res_taken ? res_target : ft_q[rd_ptr_q];
    // A mispredict squashes the same-cycle push: that fetch is already wrong-path.
    assign push       = pred_valid && pred_ready && !mispredict;

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        underflow_d   = underflow_q | (res_valid && empty);
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (resolve) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (mispredict) begin
            wr_ptr_d      = rd_ptr_q + PTR_W'(1);
            count_d       = '0;
            redirect_d    = 1'b1;
            redirect_pc_d = correct_pc;
            if (mispred_cnt_q != '1) begin
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
            end
        end else begin
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(resolve);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            underflow_q   <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            underflow_q   <= underflow_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Entry storage needs no reset; count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            taken_q[wr_ptr_q]  <= pred_taken;
            target_q[wr_ptr_q] <= pred_target;
            ft_q[wr_ptr_q]     <= pred_fallthrough;
        end
    end

    assign redirect         = redirect_q;
    assign redirect_pc      = redirect_pc_q;
    assign underflow_err    = underflow_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: reference queue model plus expected-redirect scoreboard.
module tb_branch_resolver;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic             clk;
    logic             reset;
    logic             pred_valid;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic [XLEN-1:0]  pred_fallthrough;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic [XLEN-1:0]  res_target;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             empty;
    logic             underflow_err;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    branch_resolver #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_fallthrough(pred_fallthrough),
        .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .empty(empty), .underflow_err(underflow_err),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            taken;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] ft;
    } ent_t;

    ent_t            m_q[$];
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] m_rpc;
    logic            m_uf;
    int unsigned     m_bcnt;
    int unsigned     m_mcnt;
    int              compared;
    int              mismatched;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        pred_valid = 1'b0; pred_taken = 1'b0; pred_target = '0; pred_fallthrough = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    endtask

    task automatic check_all(input logic exp_redirect);
        logic [XLEN-1:0] pc;
        chk("redirect", redirect, exp_redirect);
        if (exp_redirect) begin
            if (exp_q.size() > 0) begin
                pc = exp_q.pop_front();
                chk("redirect_pc_sb", redirect_pc, pc);
            end else begin
                chk("sb_nonempty", 1'b0, 1'b1);
            end
        end
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("empty", empty, m_q.size() == 0);
        chk("pred_ready", pred_ready, m_q.size() != DEPTH);
        chk("branch_count", branch_count, m_bcnt);
        chk("mispredict_count", mispredict_count, m_mcnt);
        chk("underflow_err", underflow_err, m_uf);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_q.delete(); exp_q.delete();
        m_rpc = '0; m_uf = 1'b0; m_bcnt = 0; m_mcnt = 0;
        check_all(1'b0);
    endtask

    // One clock: drive inputs, advance the model, then compare everything after the edge.
    task automatic cyc(input logic pv, input logic pt, input logic [XLEN-1:0] ptgt,
                       input logic [XLEN-1:0] pft, input logic rv, input logic rt,
                       input logic [XLEN-1:0] rtgt);
        logic mis;
        logic rdy;
        ent_t h;
        ent_t n;
        @(negedge clk);
        pred_valid = pv; pred_taken = pt; pred_target = ptgt; pred_fallthrough = pft;
        res_valid = rv; res_taken = rt; res_target = rtgt;
        mis = 1'b0;
        rdy = (m_q.size() != DEPTH);
        if (rv && m_q.size() == 0) begin
            m_uf = 1'b1;
        end else if (rv) begin
            h = m_q.pop_front();
            m_bcnt++;
            mis = (rt != h.taken) || (rt && (rtgt != h.target));
            if (mis) begin
                m_q.delete();
                m_mcnt++;
                m_rpc = rt ? rtgt : h.ft;
                exp_q.push_back(m_rpc);
            end
        end
        if (pv && rdy && !mis) begin
            n.taken = pt; n.target = ptgt; n.ft = pft;
            m_q.push_back(n);
        end
        @(posedge clk); #1;
        idle_inputs();
        check_all(mis);
    endtask

    task automatic push(input logic pt, input logic [XLEN-1:0] ptgt, input logic [XLEN-1:0] pft);
        cyc(1'b1, pt, ptgt, pft, 1'b0, 1'b0, '0);
    endtask

    task automatic resolve(input logic rt, input logic [XLEN-1:0] rtgt);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, rt, rtgt);
    endtask

    task automatic resolve_ok();
        if (m_q.size() > 0) resolve(m_q[0].taken, m_q[0].target);
        else                resolve(1'b0, '0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        compared = 0; mismatched = 0;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // Correctly predicted not-taken branch
        push(1'b0, 32'h100, 32'h14);
        resolve(1'b0, 32'h0);
        chk("t1_bcnt", branch_count, 32'd1);
        chk("t1_mcnt", mispredict_count, 32'd0);
        chk("t1_empty", empty, 1'b1);

        // Predicted taken, actually not taken: redirect to fall-through for one cycle
        push(1'b1, 32'h40, 32'h24);
        resolve(1'b0, 32'h0);
        chk("t2_rpc", redirect_pc, 32'h24);
        chk("t2_mcnt", mispredict_count, 32'd1);
        idle();
        chk("t2_pulse_end", redirect, 1'b0);
        chk("t2_rpc_hold", redirect_pc, 32'h24);

        // Flush with a same-cycle push that must be dropped
        push(1'b0, 32'h300, 32'h8);
        push(1'b1, 32'h310, 32'h10);
        push(1'b0, 32'h320, 32'h18);
        cyc(1'b1, 1'b1, 32'h330, 32'h1c, 1'b1, 1'b1, 32'h200);
        chk("t3_rpc", redirect_pc, 32'h200);
        chk("t3_empty", empty, 1'b1);

        // Fill, overflow push dropped, drain with wrapped pointers
        for (int i = 0; i < DEPTH; i++) begin
            push(i[0], 32'h1000 + 32'(i) * 32'h10, 32'h2000 + 32'(i) * 32'h4);
        end
        chk("t4_full", pred_ready, 1'b0);
        push(1'b1, 32'hdead, 32'hbeef);
        for (int i = 0; i < DEPTH; i++) resolve_ok();
        chk("t4_empty", empty, 1'b1);
        chk("t4_mcnt", mispredict_count, 32'd2);

        // Same-cycle push and correct pop keeps occupancy
        push(1'b1, 32'h500, 32'h504);
        cyc(1'b1, 1'b0, 32'h600, 32'h604, 1'b1, 1'b1, 32'h500);
        resolve(1'b0, 32'h0);

        // Jump with wrong target, then underflow
        push(1'b1, 32'h80, 32'h30);
        resolve(1'b1, 32'h84);
        chk("t5_rpc", redirect_pc, 32'h84);
        resolve(1'b1, 32'h90);
        chk("t5_uf", underflow_err, 1'b1);
        idle();
        chk("t5_uf_sticky", underflow_err, 1'b1);

        // Randomized mix against the model
        for (int i = 0; i < 60; i++) begin
            logic rv;
            logic rt;
            logic [XLEN-1:0] rtgt;
            rv = ($urandom_range(0, 2) == 0);
            if (rv && m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                rt = m_q[0].taken; rtgt = m_q[0].target;
            end else begin
                rt = 1'($urandom_range(0, 1)); rtgt = 32'($urandom_range(0, 3)) << 4;
            end
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 3)) << 4, 32'($urandom_range(0, 255)), rv, rt, rtgt);
        end

        // Reset right after a mispredict cancels the pending redirect
        push(1'b1, 32'h700, 32'h704);
        resolve(1'b0, 32'h0);
        do_reset();
        chk("t6_redirect", redirect, 1'b0);
        chk("t6_bcnt", branch_count, 32'd0);
        chk("t6_mcnt", mispredict_count, 32'd0);
        chk("t6_empty", empty, 1'b1);
        chk("t6_uf", underflow_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Back end of the branch prediction path: records every prediction issued at fetch (taken/not-taken, predicted target, fall-through PC) in an in-order queue.
- When execute resolves the oldest in-flight branch/jump, compares the actual outcome against the recorded prediction.
- On mismatch, issues a one-cycle redirect with the correct PC and flushes all younger (wrong-path) entries.
- Keeps saturating statistics counters for resolved branches and mispredictions.

Parameters:
XLEN, 32, address/data width
DEPTH, 4, queue entries; power of two, >= 2
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
pred_valid  input  1  fetch issued a prediction for a branch or jump this cycle
pred_taken  input  1  predicted direction
pred_target  input  XLEN  predicted target (pc_next + immediate)
pred_fallthrough  input  XLEN  sequential PC of the predicted instruction
pred_ready  output  1  queue can accept a prediction
res_valid  input  1  execute resolved the oldest outstanding branch/jump
res_taken  input  1  actual direction
res_target  input  XLEN  actual computed target
redirect  output  1  one-cycle pulse: fetch must restart at redirect_pc
redirect_pc  output  XLEN  correct next PC
empty  output  1  no outstanding predictions
underflow_err  output  1  sticky: res_valid seen while empty
branch_count  output  CNT_W  resolved entries, saturating
mispredict_count  output  CNT_W  mispredictions, saturating

Behaviour:
- Reset: queue empty (read ptr = write ptr = 0, count = 0); redirect = 0, redirect_pc = 0, underflow_err = 0, both counters = 0; pred_ready = 1, empty = 1.
- Queue: circular buffer, pointers wrap modulo DEPTH; count tracked with log2(DEPTH)+1 bits.
- pred_ready = (count != DEPTH), combinational from registered state.
- Push on pred_valid && pred_ready; pred_valid while full is dropped with no state change.
- Resolution, evaluated on res_valid && !empty against the head entry:
  - mispredict = (res_taken != head.taken) || (res_taken && res_target != head.target).
  - correct PC = res_taken ? res_target : head.fallthrough.
- Resolution timing:
  - Head is popped at the same edge; branch_count increments, saturating at all-ones.
  - On mispredict: redirect = 1 and redirect_pc = correct PC in the next cycle only (1-cycle latency, registered).
  - On mispredict: at that same edge the whole queue is flushed (count = 0, write ptr = read ptr); a push in the same cycle is discarded; mispredict_count increments, saturating.
  - On correct prediction: redirect stays 0; redirect_pc holds its previous value.
- Same-cycle push and pop without mispredict: both take effect, count unchanged. Allowed when full only if pred_ready was 1, i.e. never; when full a push is always dropped.
- res_valid while empty: ignored except that underflow_err is set; underflow_err is cleared only by reset.
- Reset asserted mid-operation: all state returns to reset values at that edge; a pending redirect is cancelled.
- Jumps are pushed with pred_taken = 1 and resolved like branches; a target mismatch still redirects.

Test Plan:
- Reset, then push {taken=0, tgt=0x100, ft=0x14}; resolve res_taken=0 -> redirect stays 0, empty=1, branch_count=1, mispredict_count=0.
- Push {taken=1, tgt=0x40, ft=0x24}; resolve res_taken=0 -> next cycle redirect=1, redirect_pc=0x24 for exactly 1 cycle; mispredict_count=1.
- Push 3 entries, first {taken=0, ft=0x8}; resolve first with res_taken=1, res_target=0x200 while pred_valid=1 -> redirect_pc=0x200, queue flushed, same-cycle push dropped, empty=1.
- Push DEPTH=4 entries -> pred_ready=0; 5th push dropped; resolve all 4 correctly -> the 4th-pushed values are the last compared, which checks pointer wrap.
- Push {taken=1, tgt=0x80}; resolve res_taken=1, res_target=0x84 -> redirect_pc=0x84; res_valid on empty -> underflow_err=1 and sticks until reset.
- Assert reset the cycle after a mispredicting resolution -> redirect=0, counters=0, empty=1 after the edge.
